// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, entry layout, FSM states and address helpers
// for the direct-mapped instruction-cache controller.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 8;
  localparam int OFFSET_W   = 4;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_WORDS = 4;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int ENTRY_W    = 149;
  localparam int VALID_BIT  = 148;
  localparam int TAG_MSB    = 147;
  localparam int TAG_LSB    = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    WRITE,
    FLUSH
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_idx(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [1:0] addr_word(
    input logic [ADDR_W-1:0] a
  );
    return a[3:2];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(
    input logic [LINE_W-1:0] line,
    input logic [1:0]        w
  );
    return line[{w, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: CPU fetch, memory line-read and BRAM port bundle.
// master = cache controller view, slave = CPU/memory/BRAM view.
interface icache_if;
  import icache_pkg::*;

  logic                 cpu_req_valid;
  logic                 cpu_req_ready;
  logic [ADDR_W-1:0]    cpu_req_addr;
  logic                 cpu_resp_valid;
  logic [WORD_W-1:0]    cpu_resp_data;

  logic                 mem_rd_req_valid;
  logic                 mem_rd_req_ready;
  logic [ADDR_W-1:0]    mem_rd_addr;
  logic                 mem_rd_resp_valid;
  logic [WORD_W-1:0]    mem_rd_resp_data;
  logic                 mem_rd_resp_last;

  logic                 bram_ena;
  logic                 bram_wea;
  logic [INDEX_W-1:0]   bram_addra;
  logic [ENTRY_W-1:0]   bram_dina;
  logic [ENTRY_W-1:0]   bram_douta;

  modport master (
    input  cpu_req_valid, cpu_req_addr,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    output mem_rd_req_valid, mem_rd_addr,
    input  mem_rd_req_ready, mem_rd_resp_valid,
    input  mem_rd_resp_data, mem_rd_resp_last,
    output bram_ena, bram_wea, bram_addra, bram_dina,
    input  bram_douta
  );

  modport slave (
    output cpu_req_valid, cpu_req_addr,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
    input  mem_rd_req_valid, mem_rd_addr,
    output mem_rd_req_ready, mem_rd_resp_valid,
    output mem_rd_resp_data, mem_rd_resp_last,
    input  bram_ena, bram_wea, bram_addra, bram_dina,
    output bram_douta
  );

endinterface

// File: rtl/icache_refill_buf.sv
// icache_refill_buf: 2-bit beat counter + 128-bit line assembler.
// Ports: clk, rst, beat_i/data_i/last_i in, sel_i word select, line_o/word_o/done_o out.
module icache_refill_buf
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              last_i,
  input  logic [1:0]        sel_i,
  output logic [LINE_W-1:0] line_o,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (beat_i) begin
      line_d[{cnt_q, 5'b0} +: WORD_W] = data_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_o = line_q;
  assign word_o = line_word(line_q, sel_i);
  assign done_o = beat_i && (cnt_q == 2'd3);

  // last is informational only: it must mark exactly the fourth beat
  a_last: assert property (
    @(posedge clk) disable iff (rst)
    beat_i |-> (last_i == (cnt_q == 2'd3))
  );

endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped I-cache controller driving a single-port BRAM.
// Ports: clk, rst (sync, high), flush, bus (icache_if.master); ICACHE_RESET_CLEAR_EN sweeps sets after reset.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  icache_if.master bus
);

  state_t             state_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] idx_q;
  logic [1:0]         word_q;
  logic [INDEX_W-1:0] fidx_q;

  logic              hit;
  logic              beat;
  logic              done;
  logic [LINE_W-1:0] buf_line;
  logic [WORD_W-1:0] buf_word;

  assign hit  = bus.bram_douta[VALID_BIT] &&
                (bus.bram_douta[TAG_MSB:TAG_LSB] == tag_q);
  assign beat = !rst && (state_q == REFILL) && bus.mem_rd_resp_valid;

  icache_refill_buf u_rbuf (
    .clk    (clk),
    .rst    (rst),
    .beat_i (beat),
    .data_i (bus.mem_rd_resp_data),
    .last_i (bus.mem_rd_resp_last),
    .sel_i  (word_q),
    .line_o (buf_line),
    .word_o (buf_word),
    .done_o (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef ICACHE_RESET_CLEAR_EN
      state_q <= FLUSH;
`else
      state_q <= IDLE;
`endif
      tag_q  <= '0;
      idx_q  <= '0;
      word_q <= '0;
      fidx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            fidx_q  <= '0;
            state_q <= FLUSH;
          end else if (bus.cpu_req_valid) begin
            tag_q   <= addr_tag(bus.cpu_req_addr);
            idx_q   <= addr_idx(bus.cpu_req_addr);
            word_q  <= addr_word(bus.cpu_req_addr);
            state_q <= LOOKUP;
          end
        end
        LOOKUP:   state_q <= hit ? IDLE : MISS_REQ;
        MISS_REQ: if (bus.mem_rd_req_ready) state_q <= REFILL;
        REFILL:   if (done) state_q <= WRITE;
        WRITE:    state_q <= IDLE;
        FLUSH: begin
          fidx_q <= fidx_q + 8'd1;
          if (fidx_q == 8'hFF) state_q <= IDLE;
        end
        default:  state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.cpu_req_ready    = 1'b0;
    bus.cpu_resp_valid   = 1'b0;
    bus.cpu_resp_data    = '0;
    bus.mem_rd_req_valid = 1'b0;
    bus.mem_rd_addr      = '0;
    bus.bram_ena         = 1'b0;
    bus.bram_wea         = 1'b0;
    bus.bram_addra       = '0;
    bus.bram_dina        = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          bus.cpu_req_ready = 1'b1;
          // read issued in the accept cycle so douta is ready in LOOKUP
          if (!flush && bus.cpu_req_valid) begin
            bus.bram_ena   = 1'b1;
            bus.bram_addra = addr_idx(bus.cpu_req_addr);
          end
        end
        LOOKUP: begin
          if (hit) begin
            bus.cpu_resp_valid = 1'b1;
            bus.cpu_resp_data  =
              line_word(bus.bram_douta[LINE_W-1:0], word_q);
          end
        end
        MISS_REQ: begin
          bus.mem_rd_req_valid = 1'b1;
          bus.mem_rd_addr      = {tag_q, idx_q, 4'b0};
        end
        WRITE: begin
          bus.bram_ena       = 1'b1;
          bus.bram_wea       = 1'b1;
          bus.bram_addra     = idx_q;
          bus.bram_dina      = {1'b1, tag_q, buf_line};
          bus.cpu_resp_valid = 1'b1;
          bus.cpu_resp_data  = buf_word;
        end
        FLUSH: begin
          bus.bram_ena   = 1'b1;
          bus.bram_wea   = 1'b1;
          bus.bram_addra = fidx_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed bench for icache_ctrl with a behavioural
// 1-cycle BRAM and hand-driven memory refill beats.
module tb_icache_ctrl;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  icache_if bus();

  icache_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [148:0] bram [256];
  int           wr_cnt = 0;
  int           wr_rst = 0;
  int           mrv_cyc = 0;
  logic [7:0]   last_wa = '0;

  initial begin
    for (int i = 0; i < 256; i++) bram[i] = '0;
    bus.bram_douta = '0;
  end

  always @(posedge clk) begin
    if (bus.bram_ena) begin
      if (bus.bram_wea) begin
        bram[bus.bram_addra] <= bus.bram_dina;
        bus.bram_douta       <= bus.bram_dina;
        wr_cnt               <= wr_cnt + 1;
        last_wa              <= bus.bram_addra;
      end else begin
        bus.bram_douta <= bram[bus.bram_addra];
      end
    end
    if (rst && bus.bram_wea) wr_rst <= wr_rst + 1;
    if (bus.mem_rd_req_valid) mrv_cyc <= mrv_cyc + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] outs();
    return 256'({bus.cpu_req_ready, bus.cpu_resp_valid,
                 bus.cpu_resp_data, bus.mem_rd_req_valid,
                 bus.mem_rd_addr, bus.bram_ena, bus.bram_wea,
                 bus.bram_addra, bus.bram_dina});
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cpu_req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_after_reset", 256'(bus.cpu_req_ready), 256'(1));
  endtask

  task automatic req(input logic [31:0] a);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    #1;
    chk("acc_ready", 256'(bus.cpu_req_ready), 256'(1));
    chk("acc_ena", 256'(bus.bram_ena), 256'(1));
    chk("acc_addra", 256'(bus.bram_addra), 256'(a[11:4]));
    chk("acc_no_resp", 256'(bus.cpu_resp_valid), 256'(0));
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
  endtask

  // LOOKUP miss, optional request stall, 4 beats, then WRITE checks
  task automatic miss(input logic [31:0] a, input logic [127:0] line,
                      input int stall);
    logic [31:0]  laddr;
    logic [148:0] ent;
    logic [31:0]  w;
    laddr = {a[31:4], 4'h0};
    ent   = {1'b1, a[31:12], line};
    w     = line[32*a[3:2] +: 32];
    @(negedge clk);
    chk("miss_no_resp", 256'(bus.cpu_resp_valid), 256'(0));
    @(posedge clk);
    for (int k = 0; k < stall; k++) begin
      #1;
      bus.mem_rd_resp_valid = (k == 1);
      bus.mem_rd_resp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stall_valid", 256'(bus.mem_rd_req_valid), 256'(1));
      chk("stall_addr", 256'(bus.mem_rd_addr), 256'(laddr));
      @(posedge clk);
    end
    #1;
    bus.mem_rd_resp_valid = 1'b0;
    bus.mem_rd_req_ready  = 1'b1;
    @(negedge clk);
    chk("mreq_valid", 256'(bus.mem_rd_req_valid), 256'(1));
    chk("mreq_addr", 256'(bus.mem_rd_addr), 256'(laddr));
    @(posedge clk);
    #1;
    bus.mem_rd_req_ready = 1'b0;
    if (stall > 0) chk("stall_cnt", 256'(dut.u_rbuf.cnt_q), 256'(0));
    for (int i = 0; i < 4; i++) begin
      bus.mem_rd_resp_valid = 1'b1;
      bus.mem_rd_resp_data  = line[32*i +: 32];
      bus.mem_rd_resp_last  = (i == 3);
      @(posedge clk);
      #1;
    end
    bus.mem_rd_resp_valid = 1'b0;
    bus.mem_rd_resp_last  = 1'b0;
    @(negedge clk);
    chk("wr_en", 256'({bus.bram_ena, bus.bram_wea}), 256'(2'b11));
    chk("wr_addra", 256'(bus.bram_addra), 256'(a[11:4]));
    chk("wr_dina", 256'(bus.bram_dina), 256'(ent));
    chk("wr_resp_valid", 256'(bus.cpu_resp_valid), 256'(1));
    chk("wr_resp_data", 256'(bus.cpu_resp_data), 256'(w));
    @(posedge clk);
  endtask

  initial begin
    int mrv0;
    int w0;
    int n;
    bus.cpu_req_valid     = 1'b0;
    bus.cpu_req_addr      = '0;
    bus.mem_rd_req_ready  = 1'b0;
    bus.mem_rd_resp_valid = 1'b0;
    bus.mem_rd_resp_data  = '0;
    bus.mem_rd_resp_last  = 1'b0;

    @(negedge clk);
    chk("rst_outs0", outs(), 256'(0));
    @(negedge clk);
    chk("rst_outs1", outs(), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready();

    // cold miss, word 1 of line 0x1000
    req(32'h0000_1004);
    miss(32'h0000_1004, {32'h44, 32'h33, 32'h22, 32'h11}, 0);

    // hit on word 3, response one clock after accept edge
    mrv0 = mrv_cyc;
    req(32'h0000_100C);
    @(negedge clk);
    chk("hit_valid", 256'(bus.cpu_resp_valid), 256'(1));
    chk("hit_data", 256'(bus.cpu_resp_data), 256'(32'h44));
    @(negedge clk);
    chk("hit_single", 256'(bus.cpu_resp_valid), 256'(0));
    chk("hit_no_memreq", 256'(mrv_cyc), 256'(mrv0));

    // conflicting tag on set 0 evicts, then original line misses
    req(32'h0010_1000);
    miss(32'h0010_1000, {32'h58, 32'h57, 32'h56, 32'h55}, 0);
    req(32'h0000_1000);
    miss(32'h0000_1000, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 5);
    req(32'h0000_1008);
    @(negedge clk);
    chk("hit2_valid", 256'(bus.cpu_resp_valid), 256'(1));
    chk("hit2_data", 256'(bus.cpu_resp_data), 256'(32'hA3));

    // flush beats a simultaneous request; request held and served after
    @(negedge clk);
    flush             = 1'b1;
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h0000_1008;
    #1;
    chk("flush_ena", 256'(bus.bram_ena), 256'(0));
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.cpu_req_ready && n < 300) begin
      n++;
      flush = (n == 10);
      @(negedge clk);
    end
    flush = 1'b0;
    chk("flush_cycles", 256'(n), 256'(256));
    chk("flush_writes", 256'(wr_cnt - w0), 256'(256));
    chk("flush_last_set", 256'(last_wa), 256'(8'hFF));
    chk("post_flush_ena", 256'(bus.bram_ena), 256'(1));
    @(posedge clk);
    #1;
    bus.cpu_req_valid = 1'b0;
    miss(32'h0000_1008, {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 0);

    // reset in the middle of a refill abandons it
    req(32'h0000_2008);
    @(negedge clk);
    chk("rr_miss", 256'(bus.cpu_resp_valid), 256'(0));
    @(posedge clk);
    #1;
    bus.mem_rd_req_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_rd_req_ready  = 1'b0;
    bus.mem_rd_resp_valid = 1'b1;
    bus.mem_rd_resp_data  = 32'h61;
    @(posedge clk);
    #1;
    bus.mem_rd_resp_data = 32'h62;
    @(posedge clk);
    #1;
    bus.mem_rd_resp_valid = 1'b0;
    rst = 1'b1;
    w0  = wr_cnt;
    @(negedge clk);
    chk("rr_outs0", outs(), 256'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rr_outs1", outs(), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rr_no_write", 256'(wr_cnt - w0), 256'(0));
    chk("rr_no_wea_rst", 256'(wr_rst), 256'(0));
    wait_ready();
    req(32'h0000_2008);
    miss(32'h0000_2008, {32'h74, 32'h73, 32'h72, 32'h71}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
